// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, read-format encodings and the L3 format function
package pipeline_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;
  localparam int HW = DW_DEF / 2;
  typedef enum logic [1:0] {FN_PASS = 2'd0, FN_LO = 2'd1, FN_HI = 2'd2, FN_SWAP = 2'd3} func_e;
  function automatic logic [DW_DEF-1:0] fmt(input func_e f, input logic [DW_DEF-1:0] d);
    return f == FN_LO   ? {{HW{1'b0}}, d[HW-1:0]} :
           f == FN_HI   ? {{HW{1'b0}}, d[DW_DEF-1:HW]} :
           f == FN_SWAP ? {d[HW-1:0], d[DW_DEF-1:HW]} : d;
  endfunction
endpackage

// File: rtl/mem_1r1w.sv
// mem_1r1w: 2^AW x DW array, sync read-before-write, read register held while en is low
module mem_1r1w #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q, rdata_d;
  always_comb rdata_d = en ? mem[raddr] : rdata_q;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/pipeline_rd_ex2.sv
// pipeline_rd_ex2: three-stage load pipeline with valid/ready back-pressure over mem_1r1w
module pipeline_rd_ex2 #(
  parameter int AW = pipeline_pkg::AW_DEF,
  parameter int DW = pipeline_pkg::DW_DEF,
  parameter int RW = pipeline_pkg::RW_DEF
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [RW-1:0] req_rd,
  input  logic [1:0]    req_func,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [RW-1:0] rsp_rd,
  output logic [AW-1:0] rsp_addr,
  output logic [15:0]   rsp_count
);
  import pipeline_pkg::*;
  logic          stall;
  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [AW-1:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [RW-1:0] rd1_q, rd1_d, rd2_q, rd2_d, rd3_q, rd3_d;
  func_e         f1_q, f1_d, f2_q, f2_d;
  logic [DW-1:0] raw, d3_q, d3_d;
  logic [15:0]   cnt_q, cnt_d;
  assign stall     = v3_q & ~rsp_ready;
  assign req_ready = ~stall;
  always_comb begin
    v1_d  = stall ? v1_q  : req_valid;
    a1_d  = stall ? a1_q  : req_addr;
    rd1_d = stall ? rd1_q : req_rd;
    f1_d  = stall ? f1_q  : func_e'(req_func);
    v2_d  = stall ? v2_q  : v1_q;
    a2_d  = stall ? a2_q  : a1_q;
    rd2_d = stall ? rd2_q : rd1_q;
    f2_d  = stall ? f2_q  : f1_q;
    v3_d  = stall ? v3_q  : v2_q;
    a3_d  = stall ? a3_q  : a2_q;
    rd3_d = stall ? rd3_q : rd2_q;
    d3_d  = stall ? d3_q  : fmt(f2_q, raw);
    cnt_d = cnt_q + 16'(v3_q & rsp_ready);
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      {v1_q, v2_q, v3_q} <= '0;
      {a1_q, a2_q, a3_q} <= '0;
      {rd1_q, rd2_q, rd3_q} <= '0;
      f1_q  <= FN_PASS;
      f2_q  <= FN_PASS;
      d3_q  <= '0;
      cnt_q <= '0;
    end else begin
      {v1_q, v2_q, v3_q} <= {v1_d, v2_d, v3_d};
      {a1_q, a2_q, a3_q} <= {a1_d, a2_d, a3_d};
      {rd1_q, rd2_q, rd3_q} <= {rd1_d, rd2_d, rd3_d};
      f1_q  <= f1_d;
      f2_q  <= f2_d;
      d3_q  <= d3_d;
      cnt_q <= cnt_d;
    end
  end
  mem_1r1w #(.AW(AW), .DW(DW)) u_mem (
    .clk(clk1), .rst(rst), .en(~stall), .raddr(a1_q), .rdata(raw),
    .we(wr_en), .waddr(wr_addr), .wdata(wr_data)
  );
  assign rsp_valid = v3_q;
  assign rsp_data  = d3_q;
  assign rsp_rd    = rd3_q;
  assign rsp_addr  = a3_q;
  assign rsp_count = cnt_q;
endmodule

// File: tb/tb_pipeline_rd_ex2.sv
// tb_pipeline_rd_ex2: scoreboard bench for the load pipeline
module tb_pipeline_rd_ex2;
  logic clk1 = 0, rst = 1, wr_en = 0, req_valid = 0, rsp_ready = 1;
  logic [7:0] wr_addr = 0, req_addr = 0, rsp_addr;
  logic [15:0] wr_data = 0, rsp_data, rsp_count;
  logic [3:0] req_rd = 0, rsp_rd;
  logic [1:0] req_func = 0;
  logic req_ready, rsp_valid;
  typedef struct packed {logic [15:0] d; logic [3:0] rd; logic [7:0] a;} exp_t;
  exp_t q[$];
  int pass_cnt = 0, tot_cnt = 0;
  logic [15:0] fv [4] = '{16'h1238, 16'h0038, 16'h0012, 16'h3812};

  pipeline_rd_ex2 dut (
    .clk1(clk1), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rd(req_rd),
    .req_func(req_func), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_addr(rsp_addr), .rsp_count(rsp_count)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, tot_cnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk1) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_rd", rsp_rd, e.rd);
        chk("rsp_addr", rsp_addr, e.a);
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge clk1); #1;
    wr_en = 0;
  endtask

  task automatic issue(input logic [7:0] a, input logic [3:0] rd, input logic [1:0] f,
                       input logic [15:0] e, input bit push);
    int n = 0;
    req_valid = 1; req_addr = a; req_rd = rd; req_func = f;
    @(negedge clk1);
    while (!req_ready && n < 100) begin n++; @(negedge clk1); end
    if (n >= 100) chk("issue_accept", req_ready, 1);
    if (push) q.push_back('{e, rd, a});
    @(posedge clk1); #1;
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin n++; @(negedge clk1); end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk1); #1;
  endtask

  task automatic pulse_rst();
    rst = 1;
    @(posedge clk1); #1;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_count", rsp_count, 0);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk1); #1;
    wr(8'd125, 16'h0A0A);
    wr(8'd126, 16'h1238);
    wr(8'd127, 16'h0005);
    rst = 0;
    @(posedge clk1); #1;
    // single request latency
    issue(8'd125, 4'd10, 2'd0, 16'h0A0A, 1);
    @(negedge clk1); chk("lat_n0", rsp_valid, 0);
    @(negedge clk1); chk("lat_n1", rsp_valid, 0);
    @(negedge clk1); chk("lat_n2", rsp_valid, 1);
    @(negedge clk1); chk("count_1", rsp_count, 1);
    @(posedge clk1); #1;
    // back-to-back formats
    for (int i = 1; i < 4; i++) issue(8'd126, 4'(i), 2'(i), fv[i], 1);
    for (int i = 0; i < 3; i++) begin @(negedge clk1); chk("b2b_valid", rsp_valid, 1); end
    @(negedge clk1); chk("b2b_gap", rsp_valid, 0);
    chk("count_4", rsp_count, 4);
    @(posedge clk1); #1;
    // stall with four requests
    rsp_ready = 0;
    issue(8'd125, 4'd1, 2'd0, 16'h0A0A, 1);
    issue(8'd126, 4'd2, 2'd1, 16'h0038, 1);
    issue(8'd127, 4'd3, 2'd0, 16'h0005, 1);
    fork
      issue(8'd126, 4'd4, 2'd3, 16'h3812, 1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk1);
          chk("stall_req_ready", req_ready, 0);
          chk("stall_valid", rsp_valid, 1);
          chk("stall_hold", rsp_data, 16'h0A0A);
        end
        @(posedge clk1); #1;
        rsp_ready = 1;
      end
    join
    drain();
    @(negedge clk1); chk("count_8", rsp_count, 8);
    @(posedge clk1); #1;
    // read-before-write ordering
    issue(8'd127, 4'd5, 2'd0, 16'h0005, 1);
    wr(8'd127, 16'h00FF);
    issue(8'd127, 4'd6, 2'd0, 16'h00FF, 1);
    drain();
    // reset with requests in flight
    issue(8'd126, 4'd7, 2'd0, 16'h1238, 0);
    issue(8'd126, 4'd8, 2'd0, 16'h1238, 0);
    pulse_rst();
    @(negedge clk1);
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_count", rsp_count, 0);
    for (int i = 0; i < 4; i++) begin @(negedge clk1); chk("no_stale", rsp_valid, 0); end
    @(posedge clk1); #1;
    issue(8'd125, 4'd9, 2'd0, 16'h0A0A, 1);
    drain();
    // count wrap
    pulse_rst();
    for (int i = 0; i < 70000; i++) issue(8'd126, 4'(i), 2'(i % 4), fv[i % 4], 1);
    drain();
    @(negedge clk1); chk("count_wrap", rsp_count, 4464);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
